// File: rtl/cordic_pkg.sv
// ---------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the rotation-mode CORDIC iteration controller:
//   - default widths and iteration count
//   - controller state encoding
//   - arctangent table, entry i = round(atan(2^-i) * 2^24 / 360)
//     (full circle = 2^24 LSB, so entry 0 = 45 deg = 0x200000)
// ---------------------------------------------------------------------------
package cordic_pkg;

  localparam int CORDIC_DATA_W  = 24;
  localparam int CORDIC_ANGLE_W = 24;
  localparam int CORDIC_ITERS   = 16;

  // Native width of the arctangent table below.
  localparam int CORDIC_ATAN_W  = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } cordic_state_e;

  localparam logic [CORDIC_ATAN_W-1:0] ATAN_LUT [16] = '{
    24'h200000, 24'h12E405, 24'h09FB38, 24'h051112,
    24'h028B0D, 24'h0145D8, 24'h00A2F6, 24'h00517C,
    24'h0028BE, 24'h00145F, 24'h000A30, 24'h000518,
    24'h00028C, 24'h000146, 24'h0000A3, 24'h000051
  };

endpackage

// File: rtl/cordic_atan_lut.sv
// ---------------------------------------------------------------------------
// cordic_atan_lut
// Combinational arctangent lookup: iteration index -> angle increment.
// Ports:
//   idx    in   4        iteration index
//   delta  out  ANGLE_W  atan(2^-idx) in angle units
// The table is stored at 24 bits; other angle widths rescale it so that
// the full circle always maps to 2^ANGLE_W.
// ---------------------------------------------------------------------------
module cordic_atan_lut
  import cordic_pkg::*;
#(
  parameter int ANGLE_W = CORDIC_ANGLE_W
) (
  input  logic [3:0]         idx,
  output logic [ANGLE_W-1:0] delta
);

  if (ANGLE_W >= CORDIC_ATAN_W) begin : g_widen
    assign delta = ANGLE_W'(ATAN_LUT[idx]) << (ANGLE_W - CORDIC_ATAN_W);
  end else begin : g_narrow
    assign delta = ANGLE_W'(ATAN_LUT[idx] >> (CORDIC_ATAN_W - ANGLE_W));
  end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// ---------------------------------------------------------------------------
// cordic_iter_ctrl
// Iteration controller and shift stage for a rotation-mode CORDIC. Holds the
// x/y/angle state, feeds the external combinational ALU each iteration and
// presents the final vector on a valid/ready result port.
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   start_valid/start_ready           start handshake (ready only in IDLE)
//   start_x/start_y/start_target      initial vector and target angle
//   x_init/y_init, x_shift/y_shift    current x/y and x/y >>> iter -> ALU
//   angle/delta_angle/target_angle    accumulated angle, atan step, target
//   select, valid                     iteration index, iterating flag
//   alu_x/alu_y/alu_angle/alu_valid   ALU results (alu_valid=0 stalls)
//   res_valid/res_ready               result handshake
//   res_x/res_y/res_angle             final vector and accumulated angle
// ---------------------------------------------------------------------------
module cordic_iter_ctrl
  import cordic_pkg::*;
#(
  parameter int DATA_W  = CORDIC_DATA_W,
  parameter int ANGLE_W = CORDIC_ANGLE_W,
  parameter int ITERS   = CORDIC_ITERS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [DATA_W-1:0]  start_x,
  input  logic [DATA_W-1:0]  start_y,
  input  logic [ANGLE_W-1:0] start_target,
  output logic [DATA_W-1:0]  x_init,
  output logic [DATA_W-1:0]  y_init,
  output logic [DATA_W-1:0]  x_shift,
  output logic [DATA_W-1:0]  y_shift,
  output logic [ANGLE_W-1:0] angle,
  output logic [ANGLE_W-1:0] delta_angle,
  output logic [ANGLE_W-1:0] target_angle,
  output logic [3:0]         select,
  output logic               valid,
  input  logic [DATA_W-1:0]  alu_x,
  input  logic [DATA_W-1:0]  alu_y,
  input  logic [ANGLE_W-1:0] alu_angle,
  input  logic               alu_valid,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DATA_W-1:0]  res_x,
  output logic [DATA_W-1:0]  res_y,
  output logic [ANGLE_W-1:0] res_angle
);

  localparam logic [3:0] ITER_LAST = 4'(ITERS - 1);

  cordic_state_e             state_q, state_d;
  logic signed [DATA_W-1:0]  x_q, x_d;
  logic signed [DATA_W-1:0]  y_q, y_d;
  logic [ANGLE_W-1:0]        angle_q, angle_d;
  logic [ANGLE_W-1:0]        target_q, target_d;
  logic [3:0]                iter_q, iter_d;
  logic                      valid_q, valid_d;
  logic                      res_valid_q, res_valid_d;
  logic [ANGLE_W-1:0]        lut_delta;

  cordic_atan_lut #(.ANGLE_W(ANGLE_W)) u_atan_lut (
    .idx   (iter_q),
    .delta (lut_delta)
  );

  // Ready is gated by rst_n directly so no start can be accepted while
  // reset is being held, even before the first reset edge.
  assign start_ready  = rst_n && (state_q == ST_IDLE);

  assign x_init       = x_q;
  assign y_init       = y_q;
  assign x_shift      = x_q >>> iter_q;
  assign y_shift      = y_q >>> iter_q;
  assign angle        = angle_q;
  assign target_angle = target_q;
  assign select       = (state_q == ST_ITER) ? iter_q : 4'd0;
  assign delta_angle  = (state_q == ST_ITER) ? lut_delta : '0;
  assign valid        = valid_q;
  assign res_valid    = res_valid_q;
  assign res_x        = x_q;
  assign res_y        = y_q;
  assign res_angle    = angle_q;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    angle_d     = angle_q;
    target_d    = target_q;
    iter_d      = iter_q;
    valid_d     = valid_q;
    res_valid_d = res_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          state_d  = ST_ITER;
          x_d      = start_x;
          y_d      = start_y;
          angle_d  = '0;
          target_d = start_target;
          iter_d   = 4'd0;
          valid_d  = 1'b1;
        end
      end
      ST_ITER: begin
        // A missing ALU result freezes everything, including the index.
        if (alu_valid) begin
          x_d     = alu_x;
          y_d     = alu_y;
          angle_d = alu_angle;
          if (iter_q == ITER_LAST) begin
            state_d     = ST_DONE;
            valid_d     = 1'b0;
            res_valid_d = 1'b1;
          end else begin
            iter_d = iter_q + 4'd1;
          end
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        valid_d     = 1'b0;
        res_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      angle_q     <= '0;
      target_q    <= '0;
      iter_q      <= '0;
      valid_q     <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      angle_q     <= angle_d;
      target_q    <= target_d;
      iter_q      <= iter_d;
      valid_q     <= valid_d;
      res_valid_q <= res_valid_d;
    end
  end

endmodule
